// File: rtl/bcd_pkg.sv
// Purpose: shared BCD definitions (FSM encoding, digit width, add-3 correction constants).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    // A digit of 5 or more doubles into 10 or more, so it is pre-corrected by 3 before the shift.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_VAL    = 4'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/dabble_digit.sv
// Purpose: one double-dabble digit correction, out = (in >= 5) ? in + 3 : in.
// Latency: combinational.
// Backpressure: none, pure function of its input.
// Ports: din  - BCD digit before the shift
//        dout - corrected digit, ready to be shifted left by one
module dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_VAL;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Purpose: sequential binary-to-packed-BCD converter (shift-and-add-3), one bit per clock.
// Latency: done pulses in the cycle after BIN_W+1 edges counted from the accepting edge; one result per BIN_W+1 cycles.
// Backpressure: start is taken only while idle; start during busy is dropped, no queuing.
// Ports: clk, rst (sync, active high); start/bin_in request; busy, done pulse,
//        bcd_out (digit 0 in [3:0], held until next done), ovf (value exceeded 10^DIG-1).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int DIG   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin_in,
    output logic                         busy,
    output logic                         done,
    output logic [BCD_DIGIT_W*DIG-1:0]   bcd_out,
    output logic                         ovf
);

    localparam int WORK_W = BCD_DIGIT_W * DIG;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    bin_reg;
    logic [WORK_W-1:0]   work_reg;
    logic                ovf_acc;

    logic                accept;
    logic                last;
    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_shl;
    logic [BIN_W-1:0]    bin_shl;
    logic                bit_out;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- add-3 correction, one instance per digit ----------------
    for (genvar d = 0; d < DIG; d++) begin : g_digit
        dabble_digit u_digit (
            .din  (work_reg[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (work_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift {work, bin} left by one. The bit falling off the top digit is a
    // lost carry of 10^DIG, i.e. the value does not fit in DIG digits.
    assign bit_out  = work_adj[WORK_W-1];
    assign work_shl = {work_adj[WORK_W-2:0], bin_reg[BIN_W-1]};
    assign bin_shl  = bin_reg << 1;

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bin_reg  <= '0;
            work_reg <= '0;
            ovf_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bin_reg  <= bin_in;
                work_reg <= '0;
                cnt      <= '0;
                ovf_acc  <= 1'b0;
                busy     <= 1'b1;
            end else if (state == ST_SHIFT) begin
                work_reg <= work_shl;
                bin_reg  <= bin_shl;
                ovf_acc  <= ovf_acc | bit_out;
                cnt      <= cnt + CNT_W'(1);
                if (last) begin
                    bcd_out <= work_shl;
                    ovf     <= ovf_acc | bit_out;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Purpose: self-checking bench, two converters (3 and 2 digits) sharing stimulus, checked against a decimal model.
// Latency: expects done exactly BIN_W edges after the accepting edge's following cycle.
// Backpressure: exercises start during busy and start held high back-to-back.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIG(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .ovf(ovf3)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIG(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reference: digits of (v mod 10^dig), packed 4 bits per digit.
    function automatic logic [31:0] ref_bcd(input int v, input int dig);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < dig; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ovf(input int v, input int dig);
        int lim = 1;
        for (int i = 0; i < dig; i++) lim = lim * 10;
        return (v >= lim) ? 32'd1 : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int v);
        chk({tag, "_bcd3"}, 32'(bcd3), ref_bcd(v, 3));
        chk({tag, "_ovf3"}, 32'(ovf3), ref_ovf(v, 3));
        chk({tag, "_bcd2"}, 32'(bcd2), ref_bcd(v, 2));
        chk({tag, "_ovf2"}, 32'(ovf2), ref_ovf(v, 2));
    endtask

    // One conversion with start pulsed for one cycle. Optionally re-asserts
    // start with a different operand while busy, which must be ignored.
    task automatic convert(input string tag, input int v, input bit glitch, input int glitch_at);
        int k;
        int early;
        logic [11:0] held;
        bin_in = 8'(v);
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy3), 32'd1);
        held  = bcd3;
        early = 0;
        for (k = 1; k <= 20; k++) begin
            if (glitch && k == glitch_at) begin
                start  = 1'b1;
                bin_in = 8'($urandom_range(0, 255));
            end else begin
                start  = 1'b0;
                bin_in = 8'($urandom);
            end
            tick();
            if (done3 || done2) break;
            if (bcd3 !== held) early++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(k), 32'(BIN_W));
        chk({tag, "_hold"}, 32'(early), 32'd0);
        check_result(tag, v);
        tick();
        chk({tag, "_done_1cyc"}, 32'(done3), 32'd0);
        chk({tag, "_idle_after"}, 32'(busy3), 32'd0);
    endtask

    initial begin
        int dones;
        int early;
        int gap;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_done", 32'(done3), 32'd0);
        chk("rst_bcd", 32'(bcd3), 32'd0);
        chk("rst_ovf", 32'(ovf3 | ovf2), 32'd0);
        rst = 1'b0;
        tick();

        // Directed corner values.
        convert("d255", 255, 1'b0, 0);
        convert("d0",   0,   1'b0, 0);
        convert("d99",  99,  1'b0, 0);
        convert("d100", 100, 1'b0, 0);
        convert("ign200", 200, 1'b1, 3);

        // Exhaustive back-to-back with start held high: every 9th cycle a done.
        for (int v = 0; v < 256; v++) begin
            bin_in = 8'(v);
            start  = 1'b1;
            tick();
            dones = 0;
            early = 0;
            for (int k = 1; k < BIN_W; k++) begin
                bin_in = 8'($urandom);
                tick();
                if (done3 || done2) early++;
            end
            tick();
            if (done3 && done2) dones = 1;
            chk("b2b_early", 32'(early), 32'd0);
            chk("b2b_done", 32'(dones), 32'd1);
            check_result("b2b", v);
        end
        start = 1'b0;
        tick();

        // Random operands, random idle gaps, random ignored starts.
        for (int n = 0; n < 150; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            convert("rnd", int'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(1, 7)));
        end

        // Reset during the 4th SHIFT cycle of 123 aborts without a done pulse.
        bin_in = 8'd123;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy3), 32'd0);
        chk("abort_bcd", 32'(bcd3), 32'd0);
        chk("abort_ovf", 32'(ovf3 | ovf2), 32'd0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done3 || done2 || busy3) dones++;
        end
        chk("abort_quiet", 32'(dones), 32'd0);
        convert("after_abort", 123, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
